// File: rtl/filter_sched_pkg.sv
// Shared types and default parameters for the stereo filter scheduler.
// Holds the controller state encoding and a counter-width helper.
package filter_sched_pkg;

  localparam int unsigned DEF_NTAPS    = 102;
  localparam int unsigned DEF_FILT_LAT = 110;
  localparam int unsigned DEF_DW       = 16;
  localparam int unsigned DEF_RW       = 39;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOAD     = 3'd1,
    ST_WAIT_REL = 3'd2,
    ST_READY    = 3'd3,
    ST_RUN_L    = 3'd4,
    ST_RUN_R    = 3'd5
  } sched_state_t;

  // Bits needed to hold values 0..n-1, never less than one.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sched_lat_timer.sv
// Loadable saturating down-counter that flags when it has reached zero.
// Times the filter latency for each channel pass.
module sched_lat_timer #(
  parameter int unsigned TW = 7
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_load,
  input  logic [TW-1:0] i_load_val,
  input  logic          i_dec,
  output logic          o_zero_c
);

  logic [TW-1:0] count;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      count <= '0;
    end else if (i_load) begin
      count <= i_load_val;
    end else if (i_dec && (count != '0)) begin
      count <= count - TW'(1);
    end
  end

  assign o_zero_c = (count == '0);

endmodule

// File: rtl/filter_scheduler.sv
// Loads NTAPS tap values into a shared filter, then time-multiplexes it over
// the left and right channel of every accepted stereo sample pair.
module filter_scheduler
  import filter_sched_pkg::*;
#(
  parameter int unsigned NTAPS    = DEF_NTAPS,
  parameter int unsigned FILT_LAT = DEF_FILT_LAT,
  parameter int unsigned DW       = DEF_DW,
  parameter int unsigned RW       = DEF_RW
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_start,
  input  logic          i_smp_valid,
  input  logic [DW-1:0] i_left,
  input  logic [DW-1:0] i_right,
  input  logic [RW-1:0] i_result,
  output logic          o_tap_wr,
  output logic [DW-1:0] o_tap,
  output logic          o_ce,
  output logic [DW-1:0] o_sample,
  output logic [RW-1:0] o_left_res,
  output logic [RW-1:0] o_right_res,
  output logic          o_res_valid,
  output logic          o_ready,
  output logic          o_overrun
);

  localparam int unsigned IW = cnt_width(NTAPS);
  localparam int unsigned TW = cnt_width(FILT_LAT);
  localparam logic [IW-1:0] IDX_LAST = IW'(NTAPS - 1);
  localparam logic [TW-1:0] LAT_LOAD = TW'(FILT_LAT - 1);

  if ((NTAPS == 0) || (longint'(NTAPS) > (longint'(1) << DW))) begin : g_bad_ntaps
    $error("filter_scheduler: NTAPS must lie in 1..2**DW");
  end
  if (FILT_LAT == 0) begin : g_bad_lat
    $error("filter_scheduler: FILT_LAT must be at least 1");
  end

  sched_state_t  state;
  logic [IW-1:0] idx;
  logic [DW-1:0] right_hold;

  logic tmr_run_c;
  logic tmr_load_c;
  logic tmr_dec_c;
  logic tmr_zero_c;

  // The o_ce cycle reloads the timer, so a stale zero from the previous pass
  // can never trigger an early capture.
  assign tmr_run_c  = (state == ST_RUN_L) || (state == ST_RUN_R);
  assign tmr_load_c = tmr_run_c && o_ce;
  assign tmr_dec_c  = tmr_run_c && !o_ce;

  sched_lat_timer #(
    .TW (TW)
  ) u_lat_timer (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_load     (tmr_load_c),
    .i_load_val (LAT_LOAD),
    .i_dec      (tmr_dec_c),
    .o_zero_c   (tmr_zero_c)
  );

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state       <= ST_IDLE;
      idx         <= '0;
      right_hold  <= '0;
      o_tap_wr    <= 1'b0;
      o_tap       <= '0;
      o_ce        <= 1'b0;
      o_sample    <= '0;
      o_left_res  <= '0;
      o_right_res <= '0;
      o_res_valid <= 1'b0;
      o_ready     <= 1'b0;
      o_overrun   <= 1'b0;
    end else begin
      o_ce        <= 1'b0;
      o_res_valid <= 1'b0;

      unique case (state)
        ST_IDLE: begin
          if (!i_start) begin
            state    <= ST_LOAD;
            idx      <= '0;
            o_tap_wr <= 1'b1;
            o_tap    <= '0;
          end
        end

        // One tap write per cycle; the tap value is its own index.
        ST_LOAD: begin
          if (idx == IDX_LAST) begin
            state    <= ST_WAIT_REL;
            o_tap_wr <= 1'b0;
          end else begin
            idx   <= idx + IW'(1);
            o_tap <= DW'(idx + IW'(1));
          end
        end

        ST_WAIT_REL: begin
          if (i_start) begin
            state   <= ST_READY;
            o_ready <= 1'b1;
          end
        end

        // A sample pair takes priority over a reload request.
        ST_READY: begin
          if (i_smp_valid) begin
            state      <= ST_RUN_L;
            right_hold <= i_right;
            o_sample   <= i_left;
            o_ce       <= 1'b1;
            o_ready    <= 1'b0;
          end else if (!i_start) begin
            state    <= ST_LOAD;
            idx      <= '0;
            o_tap_wr <= 1'b1;
            o_tap    <= '0;
            o_ready  <= 1'b0;
          end
        end

        ST_RUN_L: begin
          if (i_smp_valid) begin
            o_overrun <= 1'b1;
          end
          if (!o_ce && tmr_zero_c) begin
            state      <= ST_RUN_R;
            o_left_res <= i_result;
            o_sample   <= right_hold;
            o_ce       <= 1'b1;
          end
        end

        ST_RUN_R: begin
          if (i_smp_valid) begin
            o_overrun <= 1'b1;
          end
          if (!o_ce && tmr_zero_c) begin
            state       <= ST_READY;
            o_right_res <= i_result;
            o_res_valid <= 1'b1;
            o_ready     <= 1'b1;
          end
        end

        default: begin
          state    <= ST_IDLE;
          o_tap_wr <= 1'b0;
          o_ready  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_filter_scheduler.sv
// Scoreboard bench for filter_scheduler: tap loads, stereo runs with a
// latency-accurate filter model, overrun, reload priority and async reset.
module tb_filter_scheduler;

  localparam int NT = 102;
  localparam int FL = 110;
  localparam int DW = 16;
  localparam int RW = 39;
  localparam logic [RW-1:0] GARB = '1;

  logic          clk = 1'b0;
  logic          i_reset;
  logic          i_start;
  logic          i_smp_valid;
  logic [DW-1:0] i_left;
  logic [DW-1:0] i_right;
  logic [RW-1:0] i_result = '1;
  logic          o_tap_wr;
  logic [DW-1:0] o_tap;
  logic          o_ce;
  logic [DW-1:0] o_sample;
  logic [RW-1:0] o_left_res;
  logic [RW-1:0] o_right_res;
  logic          o_res_valid;
  logic          o_ready;
  logic          o_overrun;

  always #5 clk = ~clk;

  filter_scheduler #(
    .NTAPS(NT), .FILT_LAT(FL), .DW(DW), .RW(RW)
  ) dut (
    .i_clk       (clk),
    .i_reset     (i_reset),
    .i_start     (i_start),
    .i_smp_valid (i_smp_valid),
    .i_left      (i_left),
    .i_right     (i_right),
    .i_result    (i_result),
    .o_tap_wr    (o_tap_wr),
    .o_tap       (o_tap),
    .o_ce        (o_ce),
    .o_sample    (o_sample),
    .o_left_res  (o_left_res),
    .o_right_res (o_right_res),
    .o_res_valid (o_res_valid),
    .o_ready     (o_ready),
    .o_overrun   (o_overrun)
  );

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int taps = 0;

  typedef struct {
    logic [RW-1:0] l;
    logic [RW-1:0] r;
    int            c;
  } exp_t;
  exp_t sb_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Filter model: result = 2*sample, valid for exactly one cycle, FL cycles
  // after o_ce rises; garbage at all other times.
  logic [RW-1:0] f_pend = '0;
  int            f_cnt  = 0;
  always @(posedge clk) begin
    i_result <= GARB;
    if (o_ce) begin
      f_pend <= RW'(o_sample) << 1;
      f_cnt  <= FL - 1;
    end else if (f_cnt == 1) begin
      i_result <= f_pend;
      f_cnt    <= 0;
    end else if (f_cnt > 1) begin
      f_cnt <= f_cnt - 1;
    end
  end

  // Tap monitor: every write burst must count up from zero.
  logic prev_wr = 1'b0;
  int   tap_exp = 0;
  always @(negedge clk) begin
    if (o_tap_wr) begin
      tap_exp = prev_wr ? tap_exp + 1 : 0;
      check("tap_value", 64'(o_tap), 64'(tap_exp));
      check("ce_with_tap_wr", 64'(o_ce), 64'd0);
      taps++;
    end
    prev_wr = o_tap_wr;
  end

  // Result monitor: pops the scoreboard on every o_res_valid.
  always @(negedge clk) begin : mon_res
    exp_t e;
    if (o_res_valid) begin
      if (sb_q.size() == 0) begin
        check("unexpected_res_valid", 64'(o_res_valid), 64'd0);
      end else begin
        e = sb_q.pop_front();
        check("left_res", 64'(o_left_res), 64'(e.l));
        check("right_res", 64'(o_right_res), 64'(e.r));
        check("res_cycle", 64'(cyc), 64'(e.c));
      end
    end
  end

  task automatic check_zero(input string tag);
    $display("checking all-zero outputs: %s", tag);
    check("rst_tap_wr", 64'(o_tap_wr), 64'd0);
    check("rst_tap", 64'(o_tap), 64'd0);
    check("rst_ce", 64'(o_ce), 64'd0);
    check("rst_sample", 64'(o_sample), 64'd0);
    check("rst_left_res", 64'(o_left_res), 64'd0);
    check("rst_right_res", 64'(o_right_res), 64'd0);
    check("rst_res_valid", 64'(o_res_valid), 64'd0);
    check("rst_ready", 64'(o_ready), 64'd0);
    check("rst_overrun", 64'(o_overrun), 64'd0);
  endtask

  task automatic wait_ready(input string name);
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (o_ready) break;
    end
    check(name, 64'(o_ready), 64'd1);
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 600; i++) begin
      if (sb_q.size() == 0) break;
      @(negedge clk);
    end
    check(name, 64'(sb_q.size()), 64'd0);
  endtask

  task automatic do_load(input int hold);
    int t0;
    t0 = taps;
    @(posedge clk); #1;
    i_start = 1'b0;
    repeat (hold) @(posedge clk);
    #1;
    if (hold > NT + 2) begin
      check("hold_tap_count", 64'(taps - t0), 64'(NT));
      check("hold_tap_wr_low", 64'(o_tap_wr), 64'd0);
      check("hold_not_ready", 64'(o_ready), 64'd0);
    end
    i_start = 1'b1;
    wait_ready("load_ready");
    check("load_tap_count", 64'(taps - t0), 64'(NT));
  endtask

  task automatic send(input logic [DW-1:0] l, input logic [DW-1:0] r, input logic start_low);
    exp_t e;
    @(posedge clk); #1;
    i_left      = l;
    i_right     = r;
    i_smp_valid = 1'b1;
    if (start_low) i_start = 1'b0;
    e.l = RW'(l) << 1;
    e.r = RW'(r) << 1;
    e.c = cyc + 1 + 2 * FL + 2;
    sb_q.push_back(e);
    @(posedge clk); #1;
    i_smp_valid = 1'b0;
    i_start     = 1'b1;
    check("ce_after_accept", 64'(o_ce), 64'd1);
    check("sample_left", 64'(o_sample), 64'(l));
    check("no_tap_wr_in_run", 64'(o_tap_wr), 64'd0);
    check("not_ready_in_run", 64'(o_ready), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion, expected finish before 500000 ns");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int  t0;
    logic found;
    i_reset     = 1'b0;
    i_start     = 1'b1;
    i_smp_valid = 1'b0;
    i_left      = '0;
    i_right     = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero("power-on reset");
    i_reset = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_no_wr", 64'(o_tap_wr), 64'd0);

    // Short start pulse, then a start held well past the load.
    do_load(3);
    do_load(200);

    // Single stereo pair.
    send(16'h1234, 16'hABCD, 1'b0);
    wait_drain("drain_basic");
    wait_ready("ready_after_basic");
    check("no_overrun_yet", 64'(o_overrun), 64'd0);

    // Pair arriving 50 cycles into RUN_L is dropped and flagged.
    send(16'h0100, 16'h7FFF, 1'b0);
    repeat (50) @(posedge clk);
    #1;
    i_left      = 16'hFFFF;
    i_right     = 16'hFFFF;
    i_smp_valid = 1'b1;
    @(posedge clk); #1;
    i_smp_valid = 1'b0;
    check("overrun_set", 64'(o_overrun), 64'd1);
    wait_drain("drain_overrun");
    repeat (5) @(negedge clk);
    check("overrun_sticky", 64'(o_overrun), 64'd1);

    // Sample and reload in the same READY cycle: sample wins.
    t0 = taps;
    send(16'h0001, 16'h8000, 1'b1);
    wait_drain("drain_prio");
    wait_ready("ready_after_prio");
    check("prio_no_taps", 64'(taps - t0), 64'd0);

    // Reset in the middle of a load at index 40.
    t0 = taps;
    found = 1'b0;
    @(posedge clk); #1;
    i_start = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (o_tap_wr && (o_tap == 16'd40)) begin
        found = 1'b1;
        break;
      end
    end
    check("reached_idx40", 64'(found), 64'd1);
    i_reset = 1'b0;
    #1;
    check_zero("async reset mid-load");
    i_start = 1'b1;
    repeat (3) @(negedge clk);
    i_reset = 1'b1;
    repeat (20) @(negedge clk);
    check("no_wr_after_reset", 64'(taps - t0), 64'd41);
    check("idle_after_reset", 64'(o_ready), 64'd0);

    // Fresh load from zero, then one more pair.
    do_load(3);
    send(16'h7FFF, 16'h0002, 1'b0);
    wait_drain("drain_final");

    repeat (5) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/filter_scheduler.md
FILTER_SCHEDULER -- requirements
Module: filter_scheduler

Interface
REQ-001 Parameter NTAPS, default 102: number of tap writes issued per load sequence.
REQ-002 Parameter FILT_LAT, default 110: i_clk cycles from a o_ce pulse to a valid i_result.
REQ-003 Parameter DW, default 16: sample and tap width.
REQ-004 Parameter RW, default 39: filter result width.
REQ-005 i_clk  in  1  sole clock; all logic on its rising edge.
REQ-006 i_reset  in  1  asynchronous, active-low reset.
REQ-007 i_start  in  1  active-low tap-load request.
REQ-008 i_smp_valid  in  1  one-cycle pulse; new stereo pair on i_left/i_right; already synchronous to i_clk.
REQ-009 i_left, i_right  in  DW  stereo samples, valid in the i_smp_valid cycle.
REQ-010 i_result  in  RW  filter accumulator output.
REQ-011 o_tap_wr  out  1  tap write strobe to filter.
REQ-012 o_tap  out  DW  tap value written; equals load index.
REQ-013 o_ce  out  1  one-cycle filter sample strobe.
REQ-014 o_sample  out  DW  sample presented to filter; stable from o_ce until result capture.
REQ-015 o_left_res, o_right_res  out  RW  captured per-channel results.
REQ-016 o_res_valid  out  1  one-cycle pulse when both channel results update.
REQ-017 o_ready  out  1  high only in READY.
REQ-018 o_overrun  out  1  sticky; sample pair dropped while filter busy.

Function
REQ-019 States: IDLE, LOAD, WAIT_REL, READY, RUN_L, RUN_R; encoding in package enum.
REQ-020 IDLE: i_start low -> LOAD next cycle; else stay.
REQ-021 LOAD: o_tap_wr=1, o_tap=idx; idx counts 0..NTAPS-1, one write per cycle; after idx NTAPS-1 -> WAIT_REL; exactly NTAPS strobes.
REQ-022 WAIT_REL: o_tap_wr=0; stay while i_start low; i_start high -> READY.
REQ-023 READY: i_smp_valid -> latch i_left and i_right, o_sample<=i_left, o_ce=1 next cycle, -> RUN_L; else i_start low -> LOAD with idx=0 (reload); i_smp_valid wins if both.
REQ-024 RUN_L: latency counter loads FILT_LAT-1 on o_ce and decrements; at zero capture i_result into o_left_res, o_sample<=latched right, o_ce=1 next cycle, -> RUN_R.
REQ-025 RUN_R: same count; at zero capture i_result into o_right_res, o_res_valid=1 same cycle as that register update, -> READY.
REQ-026 Latency: o_res_valid asserts 2*FILT_LAT+2 cycles after the accepted i_smp_valid.
REQ-027 i_smp_valid outside READY: pair dropped; in RUN_L/RUN_R also sets o_overrun; o_overrun clears only on reset.
REQ-028 i_start outside IDLE/READY/WAIT_REL ignored; no reload mid-sample.
REQ-029 o_tap_wr and o_ce never high in the same cycle; o_ce only in RUN_L/RUN_R entry cycles.
REQ-030 o_tap width DW; idx zero-extended; NTAPS <= 2**DW asserted by elaboration check.

Reset
REQ-031 i_reset low: state IDLE, idx 0, counter 0, all outputs 0 (o_left_res, o_right_res, o_sample, o_overrun included), asynchronously.
REQ-032 Reset mid-LOAD or mid-RUN aborts; no o_res_valid or further o_tap_wr until a new i_start.

Structure
REQ-033 Package filter_sched_pkg: state enum, defaults for NTAPS, FILT_LAT, DW, RW.
REQ-034 One sub-module sched_lat_timer: loadable down-counter with zero flag; all else in filter_scheduler.

Verification
REQ-035 Reset, i_start low 3 cycles then high -> o_tap_wr high exactly 102 cycles, o_tap 0..101, then o_ready=1.
REQ-036 i_start held low 200 cycles -> 102 writes, WAIT_REL until release, no extra writes.
REQ-037 READY, i_smp_valid with L=0x1234 R=0xABCD, model i_result=sample*2 -> o_left_res=0x2468, o_right_res=0x1579A, o_res_valid at cycle 222.
REQ-038 Second i_smp_valid 50 cycles into RUN_L -> pair dropped, o_overrun=1, first results unaffected.
REQ-039 i_reset low at LOAD idx 40 -> all outputs 0, no o_tap_wr until next i_start; reload starts at 0.
REQ-040 i_smp_valid and i_start low same cycle in READY -> RUN_L entered, no tap write.
